// File: rtl/inst_fetch_stage_pkg.sv
// Shared constants, types and state encodings for the instruction-fetch stage.
// Defining IF_ADEL_CHECK_EN at build time enables the fetch-address alignment check.
package inst_fetch_stage_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int STALL_BUS     = 6;
    localparam int EXC_CODE_BUS  = 5;
    localparam int INST_BUS      = 32;

    typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;
    typedef logic [EXC_CODE_BUS-1:0]  exc_code_t;
    typedef logic [INST_BUS-1:0]      inst_word_t;

    localparam inst_addr_t PC_INIT  = 32'hBFC0_0000;
    localparam exc_code_t  EXC_NONE = 5'h10;
    localparam exc_code_t  EXC_ADEL = 5'h04;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // stall vector bit that holds the IF/ID register
    localparam int STALL_IF_ID = 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REQ       = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_DONE      = 3'd3;
    localparam logic [2:0] ST_DROP_REQ  = 3'd4;
    localparam logic [2:0] ST_DROP_WAIT = 3'd5;

    typedef struct packed {
        inst_addr_t pc;
        inst_word_t inst;
        exc_code_t  exc;
    } fetch_word_t;

    localparam fetch_word_t HELD_RESET = '{pc: PC_INIT, inst: 32'd0, exc: EXC_NONE};

    function automatic logic addr_misaligned(input inst_addr_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// SRAM-like instruction port between the fetch stage (master) and the AXI bridge (slave).
interface inst_fetch_stage_if;
    import inst_fetch_stage_pkg::*;

    logic       inst_req;
    inst_addr_t inst_addr;
    logic       inst_addr_ok;
    logic       inst_data_ok;
    inst_word_t inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/inst_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs one outstanding fetch and holds the word for IF/ID.
// Build option IF_ADEL_CHECK_EN: misaligned fetch addresses raise EXC_ADEL instead of issuing a request.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | just out of reset, request goes out next cycle
// ST_REQ       | inst_req raised at fetch_addr, waiting for inst_addr_ok
// ST_WAIT      | request accepted, waiting for inst_data_ok
// ST_DONE      | instruction held and valid, advances when IF/ID not stalled
// ST_DROP_REQ  | flushed while requesting; finish handshake for old address
// ST_DROP_WAIT | flushed after acceptance; discard the response, then fetch pc
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
(
    input  logic                   cpu_clk_50M,
    input  logic                   cpu_rst,
    input  logic [STALL_BUS-1:0]   stall,
    input  logic                   flush,
    input  inst_addr_t             flush_addr,
    input  logic                   jump_flag,
    input  inst_addr_t             jump_addr,
    inst_fetch_stage_if.master     inst_bus,
    output inst_addr_t             if_pc,
    output inst_addr_t             if_pc_plus_4,
    output inst_word_t             if_inst,
    output exc_code_t              if_exccode,
    output logic                   if_inst_data_ok,
    output logic                   stallreq_if
);

`ifdef IF_ADEL_CHECK_EN
    localparam logic ADEL_CHECK = 1'b1;
`else
    localparam logic ADEL_CHECK = 1'b0;
`endif

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    inst_addr_t  pc;
    inst_addr_t  pc_nxt;
    inst_addr_t  fetch_addr;
    inst_addr_t  fetch_addr_nxt;
    logic        redir_vld;
    logic        redir_vld_nxt;
    inst_addr_t  redir_addr;
    inst_addr_t  redir_addr_nxt;
    inst_addr_t  next_pc;
    fetch_word_t held;
    fetch_word_t held_nxt;
    logic        adel_fault;
    logic        advance;
    logic        unused_stall;

    assign unused_stall = ^{stall[STALL_BUS-1:STALL_IF_ID+1], stall[STALL_IF_ID-1:0]};

    assign adel_fault = ADEL_CHECK && addr_misaligned(fetch_addr);
    assign advance    = (state == ST_DONE) && (stall[STALL_IF_ID] == NOSTOP);

    always_comb begin
        if (redir_vld) begin
            next_pc = redir_addr;
        end else if (jump_flag) begin
            next_pc = jump_addr;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        fetch_addr_nxt = fetch_addr;
        redir_vld_nxt  = redir_vld;
        redir_addr_nxt = redir_addr;
        held_nxt       = held;

        // a branch seen while the delay slot is still in flight is parked until the next advance
        if (jump_flag && !advance) begin
            redir_vld_nxt  = 1'b1;
            redir_addr_nxt = jump_addr;
        end

        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (adel_fault) begin
                    held_nxt  = '{pc: fetch_addr, inst: '0, exc: EXC_ADEL};
                    state_nxt = ST_DONE;
                end else if (inst_bus.inst_addr_ok) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (inst_bus.inst_data_ok) begin
                    held_nxt  = '{pc: fetch_addr, inst: inst_bus.inst_rdata, exc: EXC_NONE};
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (advance) begin
                    pc_nxt         = next_pc;
                    fetch_addr_nxt = next_pc;
                    redir_vld_nxt  = 1'b0;
                    state_nxt      = ST_REQ;
                end
            end
            ST_DROP_REQ: begin
                if (inst_bus.inst_addr_ok) begin
                    state_nxt = ST_DROP_WAIT;
                end
            end
            ST_DROP_WAIT: begin
                if (inst_bus.inst_data_ok) begin
                    fetch_addr_nxt = pc;
                    state_nxt      = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // flush overrides everything, but a raised request must still complete its handshake
        if (flush) begin
            pc_nxt        = flush_addr;
            redir_vld_nxt = 1'b0;
            held_nxt      = held;
            case (state)
                ST_REQ: begin
                    if (adel_fault) begin
                        fetch_addr_nxt = flush_addr;
                        state_nxt      = ST_REQ;
                    end else if (inst_bus.inst_addr_ok) begin
                        state_nxt = ST_DROP_WAIT;
                    end else begin
                        state_nxt = ST_DROP_REQ;
                    end
                end
                ST_WAIT: begin
                    if (inst_bus.inst_data_ok) begin
                        fetch_addr_nxt = flush_addr;
                        state_nxt      = ST_REQ;
                    end else begin
                        state_nxt = ST_DROP_WAIT;
                    end
                end
                ST_DROP_REQ: begin
                    fetch_addr_nxt = fetch_addr;
                end
                ST_DROP_WAIT: begin
                    if (inst_bus.inst_data_ok) begin
                        fetch_addr_nxt = flush_addr;
                    end
                end
                default: begin
                    fetch_addr_nxt = flush_addr;
                    state_nxt      = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state      <= ST_IDLE;
            pc         <= PC_INIT;
            fetch_addr <= PC_INIT;
            redir_vld  <= 1'b0;
            redir_addr <= PC_INIT;
            held       <= HELD_RESET;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fetch_addr <= fetch_addr_nxt;
            redir_vld  <= redir_vld_nxt;
            redir_addr <= redir_addr_nxt;
            held       <= held_nxt;
        end
    end

    assign inst_bus.inst_req  = ((state == ST_REQ) && !adel_fault) || (state == ST_DROP_REQ);
    assign inst_bus.inst_addr = fetch_addr;

    assign if_pc           = held.pc;
    assign if_pc_plus_4    = held.pc + 32'd4;
    assign if_inst         = held.inst;
    assign if_exccode      = held.exc;
    assign if_inst_data_ok = (state == ST_DONE);
    assign stallreq_if     = (state != ST_DONE);

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: a bridge model checks request addresses, a monitor checks held words.
`timescale 1ns/1ps
module tb_inst_fetch_stage;
    import inst_fetch_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  exc;
    } resp_t;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_addr;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_inst;
    logic [4:0]  if_exccode;
    logic        if_inst_data_ok;
    logic        stallreq_if;

    inst_fetch_stage_if bus();

    inst_fetch_stage dut (
        .cpu_clk_50M    (cpu_clk_50M),
        .cpu_rst        (cpu_rst),
        .stall          (stall),
        .flush          (flush),
        .flush_addr     (flush_addr),
        .jump_flag      (jump_flag),
        .jump_addr      (jump_addr),
        .inst_bus       (bus),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_inst        (if_inst),
        .if_exccode     (if_exccode),
        .if_inst_data_ok(if_inst_data_ok),
        .stallreq_if    (stallreq_if)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    int checks   = 0;
    int failures = 0;
    int addr_lat = 0;
    int data_lat = 0;
    logic [31:0] req_q[$];
    resp_t       resp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0F0F_F0F0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        req_q.push_back(a);
        if (delivered) resp_q.push_back('{pc: a, inst: mem_word(a), exc: EXC_NONE});
    endtask

    task automatic wait_req_addr(input logic [31:0] a, output bit saw_valid);
        int n;
        n = 0;
        saw_valid = 1'b0;
        while (!(bus.inst_req === 1'b1 && bus.inst_addr === a) && n < 100) begin
            if (if_inst_data_ok === 1'b1) saw_valid = 1'b1;
            @(negedge cpu_clk_50M);
            n++;
        end
        chk("reach_req", {31'd0, n < 100}, 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (if_inst_data_ok !== 1'b1 && n < 100) begin
            @(negedge cpu_clk_50M);
            n++;
        end
        chk("reach_valid", {31'd0, n < 100}, 32'd1);
    endtask

    // bridge model: one transaction at a time, programmable handshake latencies
    task automatic serve_one();
        logic [31:0] a;
        int n;
        a = bus.inst_addr;
        if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got %h expected none", a);
        end else begin
            chk("req_addr", a, req_q.pop_front());
        end
        n = addr_lat;
        while (n > 0) begin
            bus.inst_addr_ok = 1'b0;
            @(negedge cpu_clk_50M);
            chk("req_held", {31'd0, bus.inst_req}, 32'd1);
            chk("req_addr_held", bus.inst_addr, a);
            n--;
        end
        bus.inst_addr_ok = 1'b1;
        @(negedge cpu_clk_50M);
        bus.inst_addr_ok = 1'b0;
        n = data_lat;
        while (n > 0) begin
            @(negedge cpu_clk_50M);
            n--;
        end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem_word(a);
        @(negedge cpu_clk_50M);
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'hDEAD_BEEF;
    endtask

    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        @(negedge cpu_clk_50M);
        forever begin
            if (cpu_rst === 1'b0 && bus.inst_req === 1'b1) serve_one();
            else @(negedge cpu_clk_50M);
        end
    end

    // monitor: every new DONE episode must match the next expected word
    initial begin
        logic  prev_ok;
        resp_t e;
        prev_ok = 1'b0;
        forever begin
            @(negedge cpu_clk_50M);
            if (cpu_rst === 1'b0 && if_inst_data_ok === 1'b1 && !prev_ok) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got pc %h expected none", if_pc);
                end else begin
                    e = resp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_pc_plus_4", if_pc_plus_4, e.pc + 32'd4);
                    chk("if_inst", if_inst, e.inst);
                    chk("if_exccode", {27'd0, if_exccode}, {27'd0, e.exc});
                end
            end
            prev_ok = (if_inst_data_ok === 1'b1);
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] h_pc, h_inst, h_pc4;
        logic [4:0]  h_exc;
        bit          saw;

        cpu_rst    = 1'b1;
        stall      = 6'd0;
        flush      = 1'b0;
        flush_addr = 32'd0;
        jump_flag  = 1'b0;
        jump_addr  = 32'd0;
        repeat (3) @(negedge cpu_clk_50M);

        chk("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
        chk("rst_if_pc", if_pc, 32'hBFC0_0000);
        chk("rst_if_pc_plus_4", if_pc_plus_4, 32'hBFC0_0004);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_exccode", {27'd0, if_exccode}, 32'h10);
        chk("rst_valid", {31'd0, if_inst_data_ok}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_if}, 32'd1);

        // zero-latency fetch right after reset, then a 4-cycle IF/ID stall
        expect_fetch(32'hBFC0_0000, 1'b1);
        expect_fetch(32'hBFC0_0004, 1'b1);
        cpu_rst = 1'b0;
        chk("idle_no_req", {31'd0, bus.inst_req}, 32'd0);
        @(negedge cpu_clk_50M);
        chk("first_req", {31'd0, bus.inst_req}, 32'd1);
        chk("first_req_addr", bus.inst_addr, 32'hBFC0_0000);
        @(negedge cpu_clk_50M);
        chk("wait_not_valid", {31'd0, if_inst_data_ok}, 32'd0);
        @(negedge cpu_clk_50M);
        chk("first_valid", {31'd0, if_inst_data_ok}, 32'd1);
        chk("first_pc_plus_4", if_pc_plus_4, 32'hBFC0_0004);
        chk("done_stallreq", {31'd0, stallreq_if}, 32'd0);

        stall = 6'b000010;
        h_pc = if_pc; h_inst = if_inst; h_pc4 = if_pc_plus_4; h_exc = if_exccode;
        repeat (4) begin
            @(negedge cpu_clk_50M);
            chk("stall_valid", {31'd0, if_inst_data_ok}, 32'd1);
            chk("stall_no_req", {31'd0, bus.inst_req}, 32'd0);
            chk("stall_pc", if_pc, h_pc);
            chk("stall_inst", if_inst, h_inst);
            chk("stall_pc4", if_pc_plus_4, h_pc4);
            chk("stall_exc", {27'd0, if_exccode}, {27'd0, h_exc});
        end
        stall = 6'd0;
        @(negedge cpu_clk_50M);
        chk("resume_req", {31'd0, bus.inst_req}, 32'd1);
        chk("resume_addr", bus.inst_addr, 32'hBFC0_0004);

        // branch while its delay slot (0x08) is being fetched
        expect_fetch(32'hBFC0_0008, 1'b1);
        expect_fetch(32'hBFC0_0100, 1'b1);
        wait_valid();
        wait_req_addr(32'hBFC0_0008, saw);
        jump_flag = 1'b1;
        jump_addr = 32'hBFC0_0100;
        @(negedge cpu_clk_50M);
        jump_flag = 1'b0;

        // flush in WAIT with a slow response: data for 0x104 must be discarded
        expect_fetch(32'hBFC0_0104, 1'b0);
        expect_fetch(32'hBFC0_0380, 1'b1);
        wait_req_addr(32'hBFC0_0104, saw);
        data_lat = 3;
        @(negedge cpu_clk_50M);
        flush      = 1'b1;
        flush_addr = 32'hBFC0_0380;
        @(negedge cpu_clk_50M);
        flush    = 1'b0;
        data_lat = 0;
        wait_req_addr(32'hBFC0_0380, saw);
        chk("flush_wait_no_valid", {31'd0, saw}, 32'd0);

        // flush in REQ while the bridge withholds inst_addr_ok for 3 cycles
        expect_fetch(32'hBFC0_0384, 1'b0);
        expect_fetch(32'hBFC0_0200, 1'b1);
        wait_valid();
        addr_lat = 3;
        wait_req_addr(32'hBFC0_0384, saw);
        flush      = 1'b1;
        flush_addr = 32'hBFC0_0200;
        @(negedge cpu_clk_50M);
        flush    = 1'b0;
        addr_lat = 0;
        wait_req_addr(32'hBFC0_0200, saw);
        chk("flush_req_no_valid", {31'd0, saw}, 32'd0);
        wait_valid();

`ifdef IF_ADEL_CHECK_EN
        resp_q.push_back('{pc: 32'hBFC0_0102, inst: 32'd0, exc: EXC_ADEL});
        jump_flag = 1'b1;
        jump_addr = 32'hBFC0_0102;
        @(negedge cpu_clk_50M);
        jump_flag = 1'b0;
        stall     = 6'b000010;
        chk("adel_no_req", {31'd0, bus.inst_req}, 32'd0);
        @(negedge cpu_clk_50M);
        wait_valid();
        chk("adel_exccode", {27'd0, if_exccode}, 32'h04);
        chk("adel_inst", if_inst, 32'd0);
`endif
        stall = 6'b000010;
        repeat (4) @(negedge cpu_clk_50M);
        chk("park_valid", {31'd0, if_inst_data_ok}, 32'd1);
        chk("park_no_req", {31'd0, bus.inst_req}, 32'd0);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("resp_q_empty", resp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
